// File: rtl/lfsr_stream.sv
// lfsr_stream: Galois-LFSR word generator with seed load, zero-seed substitution,
// configurable shifts per word and a valid/ready output FIFO.
module lfsr_stream #(
  parameter int                    DATA_WIDTH     = 16,
  parameter logic [DATA_WIDTH-1:0] POLY           = 16'hB400,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_SEED   = 16'hACE1,
  parameter int                    STEPS_PER_WORD = 1,
  parameter int                    FIFO_DEPTH     = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           seed_in,
  input  logic                            seed_valid,
  input  logic                            enable,
  output logic [DATA_WIDTH-1:0]           random_number,
  output logic                            random_number_valid,
  input  logic                            random_number_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            seed_zero_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = STEPS_PER_WORD > 1 ? $clog2(STEPS_PER_WORD) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS_PER_WORD - 1);
  localparam logic [LW-1:0] DEPTH = LW'(FIFO_DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_GEN, S_FULL} state_e;
  state_e fsm_q, fsm_d;
  logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d, lfsr_next;
  logic [CW-1:0] step_q, step_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic empty, pop, adv, push;
  assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
  assign empty = level_q == '0;
  // a seed load flushes the FIFO, so any pop in that cycle is dropped
  assign pop = !empty && random_number_ready && !seed_valid;
  assign adv = fsm_q == S_GEN && enable && !seed_valid && (level_q != DEPTH || pop);
  assign push = adv && step_q == LAST_STEP;
  always_comb begin
    lfsr_d = lfsr_q;
    step_d = step_q;
    wr_d = wr_q;
    rd_d = rd_q;
    level_d = level_q;
    fsm_d = fsm_q;
    err_d = 1'b0;
    if (seed_valid) begin
      lfsr_d = seed_in == '0 ? DEFAULT_SEED : seed_in;
      err_d = seed_in == '0;
      step_d = '0;
      wr_d = '0;
      rd_d = '0;
      level_d = '0;
      fsm_d = S_GEN;
    end else begin
      lfsr_d = adv ? lfsr_next : lfsr_q;
      step_d = adv ? (push ? '0 : step_q + CW'(1)) : step_q;
      wr_d = push ? wr_q + PW'(1) : wr_q;
      rd_d = pop ? rd_q + PW'(1) : rd_q;
      level_d = level_q + LW'(push) - LW'(pop);
      fsm_d = (fsm_q == S_GEN && push && !pop && level_q == DEPTH - LW'(1)) ? S_FULL :
              (fsm_q == S_FULL && pop) ? S_GEN : fsm_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= S_IDLE;
      lfsr_q <= DEFAULT_SEED;
      step_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      err_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      lfsr_q <= lfsr_d;
      step_q <= step_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
      err_q <= err_d;
    end
  end
  // storage is deliberately unreset; level and pointers define what is live
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= lfsr_next;
  end
  assign random_number = empty ? '0 : mem_q[rd_q];
  assign random_number_valid = !empty;
  assign fifo_level = level_q;
  assign seed_zero_err = err_q;
endmodule

// File: tb/tb_lfsr_stream.sv
// tb_lfsr_stream: directed and randomized checks of two lfsr_stream instances
// (1 and 4 shifts per word) against a queue-based reference model.
module tb_lfsr_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] seed_in = '0;
  logic seed_valid = 1'b0;
  logic enable = 1'b0;
  logic ready = 1'b0;
  logic [15:0] rn [2];
  logic vld [2];
  logic [2:0] lvl [2];
  logic zerr [2];
  int total = 0;
  int bad = 0;
  int popped = 0;
  logic [15:0] mst [2];
  int mcnt [2];
  int mmode [2];
  logic merr [2];
  logic [15:0] mq [2][$];
  int steps [2] = '{1, 4};

  always #5 clk = ~clk;

  lfsr_stream #(.STEPS_PER_WORD(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .seed_in(seed_in), .seed_valid(seed_valid), .enable(enable),
    .random_number(rn[0]), .random_number_valid(vld[0]), .random_number_ready(ready),
    .fifo_level(lvl[0]), .seed_zero_err(zerr[0]));
  lfsr_stream #(.STEPS_PER_WORD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .seed_in(seed_in), .seed_valid(seed_valid), .enable(enable),
    .random_number(rn[1]), .random_number_valid(vld[1]), .random_number_ready(ready),
    .fifo_level(lvl[1]), .seed_zero_err(zerr[1]));

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] lfsr_steps(input logic [15:0] x, input int n);
    logic [15:0] y = x;
    for (int i = 0; i < n; i++) y = lfsr_step(y);
    return y;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mst[k] = 16'hACE1;
      mcnt[k] = 0;
      mmode[k] = 0;
      merr[k] = 1'b0;
      mq[k].delete();
    end
  endtask

  // one clock edge of the reference: modes 0=idle 1=generating 2=stalled full
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit p, g;
      p = mq[k].size() > 0 && ready;
      g = 1'b0;
      if (seed_valid) begin
        merr[k] = seed_in == 16'h0000;
        mst[k] = merr[k] ? 16'hACE1 : seed_in;
        mcnt[k] = 0;
        mmode[k] = 1;
        mq[k].delete();
      end else begin
        merr[k] = 1'b0;
        if (mmode[k] == 1 && enable && (mq[k].size() < 4 || p)) begin
          mst[k] = lfsr_step(mst[k]);
          mcnt[k]++;
          if (mcnt[k] == steps[k]) begin
            mcnt[k] = 0;
            g = 1'b1;
          end
        end
        if (p) begin
          void'(mq[k].pop_front());
          if (k == 0) popped++;
        end
        if (g) mq[k].push_back(mst[k]);
        if (mmode[k] == 1 && g && !p && mq[k].size() == 4) mmode[k] = 2;
        else if (mmode[k] == 2 && p) mmode[k] = 1;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("valid%0d", k), 32'(vld[k]), 32'(mq[k].size() > 0));
      chk($sformatf("level%0d", k), 32'(lvl[k]), 32'(mq[k].size()));
      chk($sformatf("word%0d", k), 32'(rn[k]), 32'(mq[k].size() > 0 ? mq[k][0] : 16'h0000));
      chk($sformatf("zerr%0d", k), 32'(zerr[k]), 32'(merr[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    seed_valid = 1'b1; seed_in = 16'hFFFF; enable = 1'b1; ready = 1'b1;
    tick();
    chk("load_lat_valid", 32'(vld[0]), 32'd0);
    seed_valid = 1'b0;
    tick();
    chk("w0", 32'(rn[0]), 32'h0000CBFF);
    tick();
    chk("w1", 32'(rn[0]), 32'h0000D1FF);
    tick();
    chk("w2", 32'(rn[0]), 32'h0000DCFF);
    tick();
    chk("s4_w0", 32'(rn[1]), 32'(lfsr_steps(16'hFFFF, 4)));
    seed_valid = 1'b1; seed_in = 16'h0000;
    tick();
    chk("zero_err", 32'(zerr[0]), 32'd1);
    seed_valid = 1'b0;
    tick();
    chk("zero_err_clr", 32'(zerr[0]), 32'd0);
    chk("zero_w0", 32'(rn[0]), 32'(lfsr_step(16'hACE1)));
    tick();
    chk("zero_valid", 32'(vld[0]), 32'd1);
    ready = 1'b0; seed_valid = 1'b1; seed_in = 16'hFFFF;
    tick();
    seed_valid = 1'b0;
    repeat (6) tick();
    chk("bp_full", 32'(lvl[0]), 32'd4);
    ready = 1'b1;
    chk("bp_d0", 32'(rn[0]), 32'h0000CBFF);
    tick();
    chk("bp_d1", 32'(rn[0]), 32'h0000D1FF);
    tick();
    chk("bp_d2", 32'(rn[0]), 32'h0000DCFF);
    tick();
    chk("bp_d3", 32'(rn[0]), 32'(lfsr_step(16'hDCFF)));
    ready = 1'b0; seed_valid = 1'b1; seed_in = 16'hFFFF;
    tick();
    seed_valid = 1'b0;
    repeat (3) tick();
    chk("rs_lvl3", 32'(lvl[0]), 32'd3);
    seed_valid = 1'b1; seed_in = 16'h1234; ready = 1'b1;
    tick();
    chk("rs_flush", 32'(lvl[0]), 32'd0);
    seed_valid = 1'b0;
    tick();
    chk("rs_w0", 32'(rn[0]), 32'(lfsr_step(16'h1234)));
    popped = 0;
    for (int cyc = 0; cyc < 60000 && popped < 10000; cyc++) begin
      if (cyc == 2000) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        chk("mid_rst_level", 32'(lvl[0]), 32'd0);
        tick();
        rst_n = 1'b1;
        seed_valid = 1'b1; seed_in = 16'h0BAD;
        tick();
      end
      ready = $urandom_range(0, 9) < 7;
      enable = $urandom_range(0, 9) < 9;
      seed_valid = $urandom_range(0, 399) == 0;
      seed_in = $urandom_range(0, 3) == 0 ? 16'h0000 : 16'($urandom);
      tick();
    end
    chk("words_done", 32'(popped >= 10000), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
